// File: rtl/blackjack_pkg.sv
// Shared definitions for the card dealer: deck constants, dealer state
// encoding and the card-index-to-rank/suit/value decode.
package blackjack_pkg;

    localparam int          SEED_WIDTH      = 12;
    localparam int          DECK_SIZE       = 52;
    localparam int          RANKS           = 13;
    localparam logic [11:0] LFSR_RESET_SEED = 12'h001;

    // Sized copies of the deck bounds for 6-bit card arithmetic.
    localparam logic [5:0]  DECK_CARDS      = 6'd52;
    localparam logic [5:0]  DECK_LAST       = 6'd51;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_PROBE = 2'd2,
        ST_DONE  = 2'd3
    } dealer_state_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
        logic [3:0] value;
    } card_info_t;

    // Suits are consecutive runs of 13 cards, so a compare chain replaces
    // the divide; the rank is the offset within the run plus one.
    function automatic card_info_t card_decode(input logic [5:0] card);
        card_info_t info;
        logic [5:0] base;
        if (card >= 6'd39) begin
            info.suit = 2'd3;
            base      = 6'd39;
        end else if (card >= 6'd26) begin
            info.suit = 2'd2;
            base      = 6'd26;
        end else if (card >= 6'd13) begin
            info.suit = 2'd1;
            base      = 6'd13;
        end else begin
            info.suit = 2'd0;
            base      = 6'd0;
        end
        info.rank  = 4'(card - base) + 4'd1;
        info.value = (info.rank > 4'd10) ? 4'd10 : info.rank;
        return info;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 12-bit Fibonacci LFSR, polynomial x^12+x^11+x^10+x^4+1, advancing every
// clock. A load replaces the shift for that cycle; a zero seed is replaced
// by the reset seed so the register can never lock up at all-zeros.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset (state -> LFSR_RESET_SEED)
//   seed  - value to load
//   load  - load seed this cycle
//   lfsr  - current LFSR state
module card_lfsr
    import blackjack_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEED_WIDTH-1:0] seed,
    input  logic                  load,
    output logic [SEED_WIDTH-1:0] lfsr
);

    logic feedback;

    assign feedback = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_RESET_SEED;
        end else if (load) begin
            lfsr <= (seed == '0) ? LFSR_RESET_SEED : seed;
        end else begin
            lfsr <= {lfsr[10:0], feedback};
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without repetition from a 52-card deck. A deal request takes
// a 6-bit candidate from the LFSR, folds it into 0..51, then probes forward
// (wrapping 51 -> 0) through the dealt-card bitmap until a free card is found.
// Ports:
//   clk_50M        - system clock
//   i_Reset        - asynchronous active-high reset
//   i_Seed         - seed for the LFSR
//   i_LoadSeed     - pulse: load i_Seed into the LFSR
//   i_Deal         - pulse: request one card (ignored while busy or empty)
//   i_ShuffleDeck  - pulse: return all cards, abort any draw in progress
//   o_Card/o_Rank/o_Suit/o_Value - last dealt card and its decode
//   o_CardValid    - one-cycle pulse when the card outputs update
//   o_Busy         - draw in progress
//   o_Dealt        - cards dealt since last shuffle/reset
//   o_DeckEmpty    - all 52 cards dealt
module card_dealer
    import blackjack_pkg::*;
(
    input  logic                  clk_50M,
    input  logic                  i_Reset,
    input  logic [SEED_WIDTH-1:0] i_Seed,
    input  logic                  i_LoadSeed,
    input  logic                  i_Deal,
    input  logic                  i_ShuffleDeck,
    output logic [5:0]            o_Card,
    output logic [3:0]            o_Rank,
    output logic [1:0]            o_Suit,
    output logic [3:0]            o_Value,
    output logic                  o_CardValid,
    output logic                  o_Busy,
    output logic [5:0]            o_Dealt,
    output logic                  o_DeckEmpty
);

    logic [SEED_WIDTH-1:0] lfsr;
    dealer_state_t         state;
    logic [5:0]            cand;
    logic [DECK_SIZE-1:0]  used;
    card_info_t            cand_info;

    card_lfsr u_lfsr (
        .clk  (clk_50M),
        .rst  (i_Reset),
        .seed (i_Seed),
        .load (i_LoadSeed),
        .lfsr (lfsr)
    );

    assign cand_info   = card_decode(cand);
    assign o_DeckEmpty = (o_Dealt == DECK_CARDS);

    always_ff @(posedge clk_50M or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            cand        <= '0;
            used        <= '0;
            o_Card      <= '0;
            o_Rank      <= '0;
            o_Suit      <= '0;
            o_Value     <= '0;
            o_CardValid <= 1'b0;
            o_Busy      <= 1'b0;
            o_Dealt     <= '0;
        end else if (i_ShuffleDeck) begin
            // Card outputs deliberately keep the last dealt card.
            state       <= ST_IDLE;
            used        <= '0;
            o_Dealt     <= '0;
            o_CardValid <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_CardValid <= 1'b0;
                    if (i_Deal && !o_DeckEmpty) begin
                        cand   <= lfsr[5:0];
                        o_Busy <= 1'b1;
                        state  <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (cand >= DECK_CARDS) begin
                        cand <= cand - DECK_CARDS;
                    end
                    state <= ST_PROBE;
                end
                ST_PROBE: begin
                    if (used[cand]) begin
                        cand <= (cand == DECK_LAST) ? 6'd0 : cand + 6'd1;
                    end else begin
                        used[cand]  <= 1'b1;
                        o_Dealt     <= o_Dealt + 6'd1;
                        o_Card      <= cand;
                        o_Rank      <= cand_info.rank;
                        o_Suit      <= cand_info.suit;
                        o_Value     <= cand_info.value;
                        o_CardValid <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_CardValid <= 1'b0;
                    o_Busy      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    o_CardValid <= 1'b0;
                    o_Busy      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer. Each accepted deal pushes the expected
// card and the cycle its o_CardValid should appear into a queue; a monitor
// pops and compares on every o_CardValid.
module tb_card_dealer;

    logic        clk_50M       = 1'b0;
    logic        i_Reset       = 1'b1;
    logic [11:0] i_Seed        = 12'h000;
    logic        i_LoadSeed    = 1'b0;
    logic        i_Deal        = 1'b0;
    logic        i_ShuffleDeck = 1'b0;
    logic [5:0]  o_Card;
    logic [3:0]  o_Rank;
    logic [1:0]  o_Suit;
    logic [3:0]  o_Value;
    logic        o_CardValid;
    logic        o_Busy;
    logic [5:0]  o_Dealt;
    logic        o_DeckEmpty;

    card_dealer dut (
        .clk_50M       (clk_50M),
        .i_Reset       (i_Reset),
        .i_Seed        (i_Seed),
        .i_LoadSeed    (i_LoadSeed),
        .i_Deal        (i_Deal),
        .i_ShuffleDeck (i_ShuffleDeck),
        .o_Card        (o_Card),
        .o_Rank        (o_Rank),
        .o_Suit        (o_Suit),
        .o_Value       (o_Value),
        .o_CardValid   (o_CardValid),
        .o_Busy        (o_Busy),
        .o_Dealt       (o_Dealt),
        .o_DeckEmpty   (o_DeckEmpty)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int card;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          last_issue = 0;
    logic [11:0] m_lfsr = 12'h001;
    logic [51:0] m_used = '0;
    logic [63:0] seen = '0;

    // Hand-computed decode of selected cards.
    int tab_card[4] = '{0, 12, 22, 51};
    int tab_rank[4] = '{1, 13, 10, 13};
    int tab_suit[4] = '{0, 0, 1, 3};
    int tab_val[4]  = '{1, 10, 10, 10};

    always @(posedge clk_50M) cyc++;

    // Reference LFSR: x^12+x^11+x^10+x^4+1, load wins, zero seed -> 1.
    always @(posedge clk_50M or posedge i_Reset) begin
        if (i_Reset)
            m_lfsr = 12'h001;
        else if (i_LoadSeed)
            m_lfsr = (i_Seed == 12'h000) ? 12'h001 : i_Seed;
        else
            m_lfsr = {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[10] ^ m_lfsr[9] ^ m_lfsr[3]};
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk_50M) begin
        exp_t e;
        int   rk;
        if (!i_Reset && o_CardValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", int'(o_CardValid), 0);
            end else begin
                e  = exp_q.pop_front();
                rk = e.card % 13 + 1;
                chk("card", int'(o_Card), e.card);
                chk("rank", int'(o_Rank), rk);
                chk("suit", int'(o_Suit), e.card / 13);
                chk("value", int'(o_Value), (rk > 10) ? 10 : rk);
                chk("valid_cycle", cyc, e.cyc);
                chk("distinct", int'(seen[o_Card]), 0);
                seen[o_Card] = 1'b1;
                for (int t = 0; t < 4; t++) begin
                    if (int'(o_Card) == tab_card[t]) begin
                        chk("map_rank", int'(o_Rank), tab_rank[t]);
                        chk("map_suit", int'(o_Suit), tab_suit[t]);
                        chk("map_value", int'(o_Value), tab_val[t]);
                    end
                end
            end
        end
    end

    // Pulse i_Deal for one cycle; if a card is expected, predict it from the
    // reference LFSR value the DUT will capture and the reference bitmap.
    task automatic issue_deal(input bit expect_card);
        int   cand;
        int   k;
        exp_t e;
        @(posedge clk_50M); #1;
        i_Deal     = 1'b1;
        last_issue = cyc;
        if (expect_card) begin
            cand = int'(m_lfsr[5:0]);
            if (cand >= 52) cand -= 52;
            k = 0;
            while (m_used[cand] && k < 52) begin
                cand = (cand == 51) ? 0 : cand + 1;
                k++;
            end
            m_used[cand] = 1'b1;
            e.card = cand;
            e.cyc  = last_issue + 3 + k;
            exp_q.push_back(e);
        end
        @(posedge clk_50M); #1;
        i_Deal = 1'b0;
    endtask

    task automatic wait_valid();
        bit got = 1'b0;
        for (int i = 0; i < 70 && !got; i++) begin
            @(negedge clk_50M);
            if (o_CardValid) got = 1'b1;
        end
        chk("valid_seen", int'(got), 1);
    endtask

    task automatic load_seed(input logic [11:0] s);
        @(posedge clk_50M); #1;
        i_Seed     = s;
        i_LoadSeed = 1'b1;
        @(posedge clk_50M); #1;
        i_LoadSeed = 1'b0;
    endtask

    task automatic shuffle();
        @(posedge clk_50M); #1;
        i_ShuffleDeck = 1'b1;
        @(posedge clk_50M); #1;
        i_ShuffleDeck = 1'b0;
        m_used = '0;
        seen   = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(o_CardValid), 0);
        chk({tag, "_busy"}, int'(o_Busy), 0);
        chk({tag, "_dealt"}, int'(o_Dealt), 0);
        chk({tag, "_empty"}, int'(o_DeckEmpty), 0);
        chk({tag, "_card"}, int'(o_Card), 0);
        chk({tag, "_rank"}, int'(o_Rank), 0);
        chk({tag, "_suit"}, int'(o_Suit), 0);
        chk({tag, "_value"}, int'(o_Value), 0);
    endtask

    task automatic run_seq(output int seq[5]);
        @(posedge clk_50M); #1;
        i_Reset = 1'b1;
        repeat (2) @(posedge clk_50M);
        #1;
        i_Reset = 1'b0;
        m_used  = '0;
        seen    = '0;
        load_seed(12'h000);
        for (int i = 0; i < 5; i++) begin
            issue_deal(1'b1);
            wait_valid();
            seq[i] = int'(o_Card);
        end
    endtask

    initial begin
        int missing;
        int lat;
        int cnt;
        int last_card;
        int seq_a[5];
        int seq_b[5];

        repeat (3) @(posedge clk_50M);
        #1;
        chk_all_zero("reset");
        i_Reset = 1'b0;

        // Full deck from seed A5C; the last deal exercises the probe wrap.
        load_seed(12'hA5C);
        for (int i = 0; i < 52; i++) begin
            missing = -1;
            if (i == 51)
                for (int j = 0; j < 52; j++)
                    if (!seen[j]) missing = j;
            issue_deal(1'b1);
            wait_valid();
            chk("dealt_count", int'(o_Dealt), i + 1);
            if (i == 51) begin
                lat = cyc - last_issue;
                chk("wrap_card", int'(o_Card), missing);
                chk("wrap_latency_le_54", int'(lat <= 54), 1);
            end
        end
        @(negedge clk_50M);
        chk("full_dealt", int'(o_Dealt), 52);
        chk("full_empty", int'(o_DeckEmpty), 1);
        chk("all_cards_seen", $countones(seen), 52);

        // 53rd deal on an empty deck must be ignored.
        issue_deal(1'b0);
        cnt = 0;
        repeat (60) begin
            @(negedge clk_50M);
            if (o_Busy || o_CardValid) cnt++;
        end
        chk("empty_deal_ignored", cnt, 0);

        shuffle();
        chk("shuffle_dealt", int'(o_Dealt), 0);
        chk("shuffle_empty", int'(o_DeckEmpty), 0);

        // A few deals, then abort a draw with a shuffle.
        for (int i = 0; i < 3; i++) begin
            issue_deal(1'b1);
            wait_valid();
        end
        last_card = int'(o_Card);
        chk("pre_abort_dealt", int'(o_Dealt), 3);
        issue_deal(1'b0);
        @(posedge clk_50M); #1;
        chk("abort_busy_before", int'(o_Busy), 1);
        i_ShuffleDeck = 1'b1;
        @(posedge clk_50M); #1;
        i_ShuffleDeck = 1'b0;
        m_used = '0;
        seen   = '0;
        chk("abort_busy_after", int'(o_Busy), 0);
        chk("abort_dealt", int'(o_Dealt), 0);
        chk("abort_card_held", int'(o_Card), last_card);
        repeat (5) @(negedge clk_50M);

        // Shuffle and deal together in IDLE: shuffle wins.
        @(posedge clk_50M); #1;
        i_ShuffleDeck = 1'b1;
        i_Deal        = 1'b1;
        @(posedge clk_50M); #1;
        i_ShuffleDeck = 1'b0;
        i_Deal        = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk_50M);
            if (o_Busy || o_CardValid) cnt++;
        end
        chk("shuffle_beats_deal", cnt, 0);
        chk("shuffle_deal_dealt", int'(o_Dealt), 0);

        // Reset in the middle of a draw clears everything at once.
        for (int i = 0; i < 2; i++) begin
            issue_deal(1'b1);
            wait_valid();
        end
        issue_deal(1'b0);
        chk("midop_busy_before", int'(o_Busy), 1);
        i_Reset = 1'b1;
        #1;
        chk_all_zero("midop_reset");
        repeat (2) @(posedge clk_50M);
        #1;
        i_Reset = 1'b0;
        m_used  = '0;
        seen    = '0;
        exp_q.delete();

        // Determinism with a zero seed.
        run_seq(seq_a);
        run_seq(seq_b);
        for (int i = 0; i < 5; i++)
            chk("determinism", seq_b[i], seq_a[i]);

        repeat (5) @(negedge clk_50M);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
